ram_responder: RTL

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/ram_responder_if.sv | 23 ++
 rtl/ram_responder.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ram_responder_if.sv
// Memory request/response bus between a datapath initiator and ram_responder.
// Combinational wiring only; no latency of its own.
// Four-phase: initiator holds MOV until MOC is seen, then drops MOV to release.
interface ram_responder_if;
  logic        MOV;
  logic        RW;
  logic [1:0]  Type;
  logic [31:0] Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MOC;
  logic        ERR;

  modport master (
    output MOV, RW, Type, Address, DataIn,
    input  DataOut, MOC, ERR
  );

  modport slave (
    input  MOV, RW, Type, Address, DataIn,
    output DataOut, MOC, ERR
  );
endinterface

// File: rtl/ram_responder.sv
// Byte-addressed big-endian RAM answering byte/halfword/word requests with fault detection.
// MOC rises LATENCY edges after the capture edge; DataOut/ERR are registered with MOC.
// Four-phase: MOC holds while MOV stays high; MOV low in BUSY aborts, MOV low in ACK releases.
module ram_responder #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input  logic           clk,
  input  logic           reset,
  ram_responder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rw_q, rw_d;
  logic [1:0]    type_q, type_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   din_q, din_d;
  logic [31:0]   dout_q, dout_d;
  logic          moc_q, moc_d;
  logic          err_q, err_d;
  logic          mem_we;

  logic [7:0]    mem [DEPTH];

  logic [2:0]    size;
  logic [32:0]   end_addr;
  logic          fault;
  logic [AW-1:0] idx0, idx1, idx2, idx3;
  logic [31:0]   rd_data;

  assign bus.DataOut = dout_q;
  assign bus.MOC     = moc_q;
  assign bus.ERR     = err_q;

  // Decode the latched request: access size, fault check and big-endian read data.
  always_comb begin
    case (type_q)
      2'b00:   size = 3'd1;
      2'b01:   size = 3'd2;
      default: size = 3'd4;
    endcase
    // 33-bit sum so addresses near 2^32 cannot wrap past the range check.
    end_addr = {1'b0, addr_q} + 33'(size);
    fault = (type_q == 2'b11)
         || (type_q == 2'b01 && addr_q[0])
         || (type_q == 2'b10 && addr_q[1:0] != 2'b00)
         || (end_addr > 33'(DEPTH));
    idx0 = addr_q[AW-1:0];
    idx1 = idx0 + AW'(1);
    idx2 = idx0 + AW'(2);
    idx3 = idx0 + AW'(3);
    case (type_q)
      2'b00:   rd_data = {24'b0, mem[idx0]};
      2'b01:   rd_data = {16'b0, mem[idx0], mem[idx1]};
      default: rd_data = {mem[idx0], mem[idx1], mem[idx2], mem[idx3]};
    endcase
  end

  // Next-state and output logic for the IDLE/BUSY/ACK handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    type_d  = type_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    moc_d   = moc_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.MOV) begin
          rw_d    = bus.RW;
          type_d  = bus.Type;
          addr_d  = bus.Address;
          din_d   = bus.DataIn;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (!bus.MOV) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(LATENCY - 1)) begin
          state_d = ACK;
          moc_d   = 1'b1;
          err_d   = fault;
          dout_d  = (fault || !rw_q) ? 32'b0 : rd_data;
          // Reset wins over a completing write so a cancelled access never lands.
          mem_we  = !fault && !rw_q && !reset;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ACK: begin
        if (!bus.MOV) begin
          state_d = IDLE;
          moc_d   = 1'b0;
          err_d   = 1'b0;
          dout_d  = 32'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and response registers; request fields need no reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= 32'b0;
      moc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      moc_q   <= moc_d;
      err_q   <= err_d;
    end
    rw_q   <= rw_d;
    type_q <= type_d;
    addr_q <= addr_d;
    din_q  <= din_d;
  end

  // Storage write, most significant byte at the lowest address; untouched by reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      case (type_q)
        2'b00: mem[idx0] <= din_q[7:0];
        2'b01: begin
          mem[idx0] <= din_q[15:8];
          mem[idx1] <= din_q[7:0];
        end
        default: begin
          mem[idx0] <= din_q[31:24];
          mem[idx1] <= din_q[23:16];
          mem[idx2] <= din_q[15:8];
          mem[idx3] <= din_q[7:0];
        end
      endcase
    end
  end

endmodule
